// File: rtl/aes256_inv_key_schedule.sv
// aes256_inv_key_schedule: streams AES-256 round keys 14..0 by inverting the forward key expansion
module aes256_inv_key_schedule (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [0:255] LAST_KEY,
  output logic [0:127] RK,
  output logic [0:3]   RK_IDX,
  output logic         RK_VALID,
  input  logic         RK_READY,
  output logic         BUSY,
  output logic         DONE
);
  typedef enum logic {IDLE, STREAM} state_t;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, m;
    p = '0;
    m = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ m : p;
      m = xt(m);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p, r;
    p = x;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  state_t       state_q, state_d;
  logic [0:255] win_q, win_d;
  logic [3:0]   idx_q, idx_d;
  logic         valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic [3:0]   r;
  logic [7:0]   rcon;
  logic [31:0]  v3, v4, v5, v6, v7, t;
  logic [0:127] new_w;

  // one inverse step: recover the round idx-1 words from the current 8-word window
  always_comb begin
    v3    = win_q[96 +: 32];
    v4    = win_q[128 +: 32];
    v5    = win_q[160 +: 32];
    v6    = win_q[192 +: 32];
    v7    = win_q[224 +: 32];
    r     = idx_q - 4'd1;
    rcon  = 8'h01 << r[3:1];
    t     = r[0] ? sub_word(v3) : sub_word({v3[23:0], v3[31:24]}) ^ {rcon, 24'h0};
    new_w = {v4 ^ t, v5 ^ v4, v6 ^ v5, v7 ^ v6};
  end

  // load in IDLE, advance the window on each accepted beat, finish after round 0
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (START) begin
        state_d = STREAM;
        win_d   = LAST_KEY;
        idx_d   = 4'd14;
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
    end else if (valid_q && RK_READY) begin
      if (idx_q == 4'd0) begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        idx_d = idx_q - 4'd1;
        win_d = (idx_q == 4'd14) ? win_q : {new_w, win_q[0:127]};
      end
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      win_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign RK       = (idx_q == 4'd14) ? win_q[128:255] : win_q[0:127];
  assign RK_IDX   = idx_q;
  assign RK_VALID = valid_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
endmodule

// File: tb/tb_aes256_inv_key_schedule.sv
// tb_aes256_inv_key_schedule: random and known-answer checks against a forward-expansion model
module tb_aes256_inv_key_schedule;
  logic         CLK = 1'b0, RST = 1'b1, START = 1'b0, RK_READY = 1'b0;
  logic [0:255] LAST_KEY = '0;
  logic [0:127] RK;
  logic [0:3]   RK_IDX;
  logic         RK_VALID, BUSY, DONE;
  int           checks = 0, errors = 0;
  logic [31:0]  w [0:59];
  logic [127:0] exp_rk [0:14];
  logic [127:0] got_rk [0:14];
  logic [7:0]   sb [0:255];

  aes256_inv_key_schedule dut (
    .CLK(CLK), .RST(RST), .START(START), .LAST_KEY(LAST_KEY), .RK(RK), .RK_IDX(RK_IDX),
    .RK_VALID(RK_VALID), .RK_READY(RK_READY), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [131:0] got, input logic [131:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic build_sbox();
    logic [7:0] ex [0:255];
    int lg [0:255];
    logic [7:0] e, inv, c, s;
    e = 8'h01;
    c = 8'h63;
    for (int i = 0; i < 255; i++) begin
      ex[i] = e;
      lg[e] = i;
      e = e ^ xt(e);
    end
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
      for (int j = 0; j < 8; j++)
        s[j] = inv[j] ^ inv[(j + 4) % 8] ^ inv[(j + 5) % 8] ^ inv[(j + 6) % 8] ^ inv[(j + 7) % 8] ^ c[j];
      sb[x] = s;
    end
  endtask

  function automatic logic [31:0] sub(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key);
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i - 1];
      if (i % 8 == 0) begin
        t = sub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) t = sub(t);
      w[i] = w[i - 8] ^ t;
    end
    for (int r = 0; r < 15; r++) exp_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    LAST_KEY = {w[52], w[53], w[54], w[55], w[56], w[57], w[58], w[59]};
  endtask

  task automatic run(input int duty, input bit use_model, input bit pokes);
    int e = 14;
    int cyc = 0;
    logic [131:0] prev = '0;
    bit stalled = 0;
    bit rdy;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    while (e >= 0 && cyc < 300) begin
      if (stalled) chk("hold", {RK_IDX, RK}, prev);
      chk("valid", 132'(RK_VALID), 132'd1);
      chk("busy", 132'(BUSY), 132'd1);
      chk("done_lo", 132'(DONE), 132'd0);
      chk("idx", 132'(RK_IDX), 132'(e));
      if (use_model) chk("rk", 132'(RK), 132'(exp_rk[e]));
      got_rk[e] = RK;
      rdy = ($urandom_range(99) < duty) || (pokes && e == 0);
      RK_READY = rdy;
      START = pokes && (e == 9 || e == 0);
      prev = {RK_IDX, RK};
      stalled = !rdy;
      if (rdy) e--;
      @(negedge CLK);
      cyc++;
    end
    START = 1'b0;
    RK_READY = 1'b0;
    chk("beats_left", 132'(e + 1), 132'd0);
    chk("done", 132'(DONE), 132'd1);
    chk("busy_end", 132'(BUSY), 132'd0);
    chk("valid_end", 132'(RK_VALID), 132'd0);
  endtask

  initial begin
    build_sbox();
    repeat (2) @(negedge CLK);
    chk("rst_rk", 132'(RK), 132'd0);
    chk("rst_idx", 132'(RK_IDX), 132'd0);
    chk("rst_valid", 132'(RK_VALID), 132'd0);
    chk("rst_busy", 132'(BUSY), 132'd0);
    chk("rst_done", 132'(DONE), 132'd0);
    RST = 1'b0;
    @(negedge CLK);
    LAST_KEY = '0;
    run(100, 0, 0);
    chk("zero_lk_14", 132'(got_rk[14]), 132'd0);
    chk("zero_lk_13", 132'(got_rk[13]), 132'd0);
    @(negedge CLK);
    chk("done_once", 132'(DONE), 132'd0);
    expand(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
    run(100, 1, 0);
    chk("a3_idx2", 132'(got_rk[2]), 132'h9ba354118e6925afa51a8b5f2067fcde);
    chk("a3_idx1", 132'(got_rk[1]), 132'h1f352c073b6108d72d9810a30914dff4);
    chk("a3_idx0", 132'(got_rk[0]), 132'h603deb1015ca71be2b73aef0857d7781);
    @(negedge CLK);
    expand('0);
    run(100, 1, 0);
    chk("zk_idx3", 132'(got_rk[3]), 132'haafbfbfbaafbfbfbaafbfbfbaafbfbfb);
    chk("zk_idx2", 132'(got_rk[2]), 132'h62636363626363636263636362636363);
    chk("zk_idx1", 132'(got_rk[1]), 132'd0);
    chk("zk_idx0", 132'(got_rk[0]), 132'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      expand({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      run(40, 1, 0);
    end
    @(negedge CLK);
    expand({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    run(100, 1, 1);
    @(negedge CLK);
    chk("poke_idle", 132'(RK_VALID), 132'd0);
    run(100, 1, 0);
    @(negedge CLK);
    expand({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    RK_READY = 1'b1;
    for (int c = 0; c < 40 && RK_IDX != 4'd7; c++) @(negedge CLK);
    RK_READY = 1'b0;
    chk("reach7", 132'(RK_IDX), 132'd7);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("mid_rst_valid", 132'(RK_VALID), 132'd0);
    chk("mid_rst_busy", 132'(BUSY), 132'd0);
    chk("mid_rst_rk", 132'(RK), 132'd0);
    chk("mid_rst_done", 132'(DONE), 132'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("mid_rst_no_done", 132'(DONE), 132'd0);
    end
    run(40, 1, 0);
    @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
